// File: rtl/ahb_lite_cmd_master_if.sv
// Command-port and AHB-Lite master-port signals of ahb_lite_cmd_master.
// The master modport is the engine's view; the slave modport is the agent/bus side.
interface ahb_lite_cmd_master_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [2:0]  CMD_SIZE;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE;
  logic [2:0]  M_HSIZE;
  logic [2:0]  M_HBURST;
  logic [3:0]  M_HPROT;
  logic        M_HMASTLOCK;
  logic [31:0] M_HADDR;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic [31:0] M_HRDATA;
  logic        M_HRESP;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_SIZE, CMD_ADDR, CMD_WDATA,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK, M_HADDR, M_HWDATA,
    input  M_HREADY, M_HRDATA, M_HRESP
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_SIZE, CMD_ADDR, CMD_WDATA,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK, M_HADDR, M_HWDATA,
    output M_HREADY, M_HRDATA, M_HRESP
  );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite master engine: valid/ready commands become single pipelined transfers
// (address stage A overlapping data stage D), with wait-state and ERROR handling.
module ahb_lite_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic             CLK,
  input logic             RES,
  ahb_lite_cmd_master_if.master io_bus
);

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } a_stage_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [1:0]  off;
    logic [31:0] wdata;
  } d_stage_t;

  logic     r_a_vld, r_d_vld, r_err_pend;
  a_stage_t r_a;
  d_stage_t r_d;
  logic        r_rsp_vld, r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_legal, w_adv, w_ready, w_acc, w_d_done;
  logic [31:0] w_lane_wdata, w_shift, w_rdata;

  always_comb begin
    w_legal = 1'b0;
    case (io_bus.CMD_SIZE)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = ~io_bus.CMD_ADDR[0];
      3'b010:  w_legal = (io_bus.CMD_ADDR[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Replicate narrow write data across all byte lanes so the slave can pick any lane.
  always_comb begin
    w_lane_wdata = io_bus.CMD_WDATA;
    case (io_bus.CMD_SIZE)
      3'b000:  w_lane_wdata = {4{io_bus.CMD_WDATA[7:0]}};
      3'b001:  w_lane_wdata = {2{io_bus.CMD_WDATA[15:0]}};
      default: w_lane_wdata = io_bus.CMD_WDATA;
    endcase
  end

  always_comb begin
    w_shift = io_bus.M_HRDATA >> {r_d.off, 3'b000};
    w_rdata = w_shift;
    case (r_d.size)
      3'b000:  w_rdata = {24'h0, w_shift[7:0]};
      3'b001:  w_rdata = {16'h0, w_shift[15:0]};
      default: w_rdata = w_shift;
    endcase
  end

  // Illegal commands answer immediately, so they wait for an empty pipe to keep order.
  assign w_adv    = r_a_vld & io_bus.M_HREADY & ~r_err_pend;
  assign w_ready  = w_legal ? (~r_a_vld | w_adv) : (~r_a_vld & ~r_d_vld);
  assign w_acc    = io_bus.CMD_VALID & w_ready;
  assign w_d_done = r_d_vld & io_bus.M_HREADY;

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_a_vld     <= 1'b0;
      r_d_vld     <= 1'b0;
      r_err_pend  <= 1'b0;
      r_a         <= '0;
      r_d         <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // First ERROR cycle seen: cancel the next address phase for one cycle.
      r_err_pend <= r_d_vld & io_bus.M_HRESP & ~io_bus.M_HREADY;
      r_rsp_vld  <= 1'b0;

      if (w_d_done) begin
        r_rsp_vld   <= 1'b1;
        r_rsp_err   <= io_bus.M_HRESP;
        r_rsp_rdata <= (io_bus.M_HRESP | r_d.write) ? 32'h0 : w_rdata;
      end

      if (w_adv) begin
        r_d_vld   <= 1'b1;
        r_d.write <= r_a.write;
        r_d.size  <= r_a.size;
        r_d.off   <= r_a.addr[1:0];
        r_d.wdata <= r_a.wdata;
      end else if (w_d_done) begin
        r_d_vld <= 1'b0;
      end

      if (w_acc & w_legal) begin
        r_a_vld   <= 1'b1;
        r_a.write <= io_bus.CMD_WRITE;
        r_a.size  <= io_bus.CMD_SIZE;
        r_a.addr  <= io_bus.CMD_ADDR;
        r_a.wdata <= w_lane_wdata;
      end else if (w_adv) begin
        r_a_vld <= 1'b0;
      end

      if (w_acc & ~w_legal) begin
        r_rsp_vld   <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= 32'h0;
      end
    end
  end

  assign io_bus.CMD_READY   = w_ready;
  assign io_bus.RSP_VALID   = r_rsp_vld;
  assign io_bus.RSP_RDATA   = r_rsp_rdata;
  assign io_bus.RSP_ERR     = r_rsp_err;
  assign io_bus.M_HTRANS    = (r_a_vld & ~r_err_pend) ? 2'b10 : 2'b00;
  assign io_bus.M_HWRITE    = r_a.write;
  assign io_bus.M_HSIZE     = r_a.size;
  assign io_bus.M_HADDR     = r_a.addr;
  assign io_bus.M_HWDATA    = r_d.wdata;
  assign io_bus.M_HBURST    = 3'b000;
  assign io_bus.M_HPROT     = HPROT_VAL;
  assign io_bus.M_HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: the bench plays both the command agent
// and the AHB slave cycle by cycle, checking against hand-computed values.
module tb_ahb_lite_cmd_master;
  logic CLK = 1'b0;
  logic RES = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  ahb_lite_cmd_master_if bus ();

  ahb_lite_cmd_master #(.HPROT_VAL(4'b0011)) dut (
    .CLK    (CLK),
    .RES    (RES),
    .io_bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_SIZE  = sz;
    bus.CMD_ADDR  = a;
    bus.CMD_WDATA = d;
  endtask

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_SIZE  = 3'b000;
    bus.CMD_ADDR  = 32'h0;
    bus.CMD_WDATA = 32'h0;
    bus.M_HREADY  = 1'b1;
    bus.M_HRDATA  = 32'h0;
    bus.M_HRESP   = 1'b0;
    step(); step();

    // reset state
    chk("rst_htrans", 32'(bus.M_HTRANS), 32'h0);
    chk("rst_haddr", bus.M_HADDR, 32'h0);
    chk("rst_hwdata", bus.M_HWDATA, 32'h0);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'h0);
    chk("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
    RES = 1'b0;
    chk("rst_cmd_ready", 32'(bus.CMD_READY), 32'h1);
    chk("hburst", 32'(bus.M_HBURST), 32'h0);
    chk("hprot", 32'(bus.M_HPROT), 32'h3);

    // T1: word write then word read @0x10, zero waits
    cmd(1'b1, 3'b010, 32'h10, 32'h12345678);
    step();
    cmd(1'b0, 3'b010, 32'h10, 32'h0);
    chk("t1_wr_htrans", 32'(bus.M_HTRANS), 32'h2);
    chk("t1_wr_haddr", bus.M_HADDR, 32'h10);
    chk("t1_wr_hwrite", 32'(bus.M_HWRITE), 32'h1);
    chk("t1_wr_hsize", 32'(bus.M_HSIZE), 32'h2);
    chk("t1_rd_ready", 32'(bus.CMD_READY), 32'h1);
    step();
    bus.CMD_VALID = 1'b0;
    chk("t1_hwdata", bus.M_HWDATA, 32'h12345678);
    chk("t1_rd_htrans", 32'(bus.M_HTRANS), 32'h2);
    chk("t1_rd_hwrite", 32'(bus.M_HWRITE), 32'h0);
    chk("t1_wr_no_rsp_yet", 32'(bus.RSP_VALID), 32'h0);
    step();
    bus.M_HRDATA = 32'h12345678;
    chk("t1_wr_rsp_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t1_wr_rsp_err", 32'(bus.RSP_ERR), 32'h0);
    chk("t1_wr_rsp_rdata", bus.RSP_RDATA, 32'h0);
    chk("t1_idle", 32'(bus.M_HTRANS), 32'h0);
    step();
    bus.M_HRDATA = 32'h0;
    chk("t1_rd_rsp_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t1_rd_rsp_rdata", bus.RSP_RDATA, 32'h12345678);
    chk("t1_rd_rsp_err", 32'(bus.RSP_ERR), 32'h0);
    step();
    chk("t1_pulse_end", 32'(bus.RSP_VALID), 32'h0);

    // T2: byte writes 0x5A @0x21 and @0x23 with two wait states
    cmd(1'b1, 3'b000, 32'h21, 32'h5A);
    step();
    cmd(1'b1, 3'b000, 32'h23, 32'h5A);
    chk("t2_haddr0", bus.M_HADDR, 32'h21);
    chk("t2_hsize", 32'(bus.M_HSIZE), 32'h0);
    step();
    bus.CMD_VALID = 1'b0;
    bus.M_HREADY  = 1'b0;
    chk("t2_hwdata_w1", bus.M_HWDATA, 32'h5A5A5A5A);
    chk("t2_haddr_w1", bus.M_HADDR, 32'h23);
    step();
    chk("t2_haddr_w2", bus.M_HADDR, 32'h23);
    chk("t2_htrans_w2", 32'(bus.M_HTRANS), 32'h2);
    chk("t2_hwdata_w2", bus.M_HWDATA, 32'h5A5A5A5A);
    chk("t2_no_rsp_wait", 32'(bus.RSP_VALID), 32'h0);
    step();
    bus.M_HREADY = 1'b1;
    chk("t2_haddr_w3", bus.M_HADDR, 32'h23);
    chk("t2_no_rsp_wait2", 32'(bus.RSP_VALID), 32'h0);
    step();
    chk("t2_rsp0", 32'(bus.RSP_VALID), 32'h1);
    chk("t2_rsp0_err", 32'(bus.RSP_ERR), 32'h0);
    chk("t2_hwdata1", bus.M_HWDATA, 32'h5A5A5A5A);
    chk("t2_idle", 32'(bus.M_HTRANS), 32'h0);
    step();
    chk("t2_rsp1", 32'(bus.RSP_VALID), 32'h1);
    step();
    chk("t2_rsp_end", 32'(bus.RSP_VALID), 32'h0);

    // T3: half read @0x2 and byte read @0x1 from 0xBEEF1234
    cmd(1'b0, 3'b001, 32'h2, 32'h0);
    step();
    cmd(1'b0, 3'b000, 32'h1, 32'h0);
    step();
    bus.CMD_VALID = 1'b0;
    bus.M_HRDATA  = 32'hBEEF1234;
    step();
    chk("t3_half_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t3_half_rdata", bus.RSP_RDATA, 32'h0000BEEF);
    step();
    chk("t3_byte_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t3_byte_rdata", bus.RSP_RDATA, 32'h00000012);
    bus.M_HRDATA = 32'h0;
    step();

    // T4: read @0x40 gets ERROR while read @0x44 waits in the address stage
    cmd(1'b0, 3'b010, 32'h40, 32'h0);
    step();
    cmd(1'b0, 3'b010, 32'h44, 32'h0);
    step();
    bus.CMD_VALID = 1'b0;
    bus.M_HREADY  = 1'b0;
    bus.M_HRESP   = 1'b1;
    bus.M_HRDATA  = 32'hDEADBEEF;
    chk("t4_htrans_e1", 32'(bus.M_HTRANS), 32'h2);
    chk("t4_haddr_e1", bus.M_HADDR, 32'h44);
    step();
    bus.M_HREADY = 1'b1;
    chk("t4_htrans_e2_idle", 32'(bus.M_HTRANS), 32'h0);
    chk("t4_ready_e2", 32'(bus.CMD_READY), 32'h0);
    chk("t4_no_rsp_e2", 32'(bus.RSP_VALID), 32'h0);
    step();
    bus.M_HRESP = 1'b0;
    chk("t4_err_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t4_err_flag", 32'(bus.RSP_ERR), 32'h1);
    chk("t4_err_rdata", bus.RSP_RDATA, 32'h0);
    chk("t4_reissue_htrans", 32'(bus.M_HTRANS), 32'h2);
    chk("t4_reissue_haddr", bus.M_HADDR, 32'h44);
    step();
    bus.M_HRDATA = 32'hCAFEF00D;
    chk("t4_idle_after", 32'(bus.M_HTRANS), 32'h0);
    chk("t4_one_err_pulse", 32'(bus.RSP_VALID), 32'h0);
    step();
    chk("t4_ok_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t4_ok_err", 32'(bus.RSP_ERR), 32'h0);
    chk("t4_ok_rdata", bus.RSP_RDATA, 32'hCAFEF00D);
    bus.M_HRDATA = 32'h0;
    step();

    // T5: misaligned word write, then an illegal size
    cmd(1'b1, 3'b010, 32'h102, 32'hFFFFFFFF);
    chk("t5_ready", 32'(bus.CMD_READY), 32'h1);
    step();
    bus.CMD_VALID = 1'b0;
    chk("t5_rsp_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t5_rsp_err", 32'(bus.RSP_ERR), 32'h1);
    chk("t5_rsp_rdata", bus.RSP_RDATA, 32'h0);
    chk("t5_no_nonseq", 32'(bus.M_HTRANS), 32'h0);
    step();
    chk("t5_pulse_end", 32'(bus.RSP_VALID), 32'h0);
    chk("t5_no_nonseq2", 32'(bus.M_HTRANS), 32'h0);
    cmd(1'b0, 3'b011, 32'h0, 32'h0);
    step();
    bus.CMD_VALID = 1'b0;
    chk("t5_size_valid", 32'(bus.RSP_VALID), 32'h1);
    chk("t5_size_err", 32'(bus.RSP_ERR), 32'h1);
    chk("t5_size_htrans", 32'(bus.M_HTRANS), 32'h0);
    step();

    // T6: reset during a wait state discards pending work
    cmd(1'b1, 3'b010, 32'h80, 32'h11112222);
    step();
    cmd(1'b0, 3'b010, 32'h84, 32'h0);
    step();
    bus.CMD_VALID = 1'b0;
    bus.M_HREADY  = 1'b0;
    step();
    RES = 1'b1;
    step();
    chk("t6_htrans_idle", 32'(bus.M_HTRANS), 32'h0);
    chk("t6_rsp_valid", 32'(bus.RSP_VALID), 32'h0);
    RES = 1'b0;
    bus.M_HREADY = 1'b1;
    chk("t6_cmd_ready", 32'(bus.CMD_READY), 32'h1);
    step();
    chk("t6_no_rsp1", 32'(bus.RSP_VALID), 32'h0);
    chk("t6_htrans_idle2", 32'(bus.M_HTRANS), 32'h0);
    step();
    chk("t6_no_rsp2", 32'(bus.RSP_VALID), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
